fetch_unit: RTL
===============

# fetch_unit

Instruction fetch sequencer and instruction register for the multicycle processor. It supplies `op` (and the remaining instruction fields) to `statelogic` and consumes its `state` output. When `statelogic` enters FETCH, this block reads one word from instruction memory over a req/ready handshake, latches it, advances the PC, and holds `statelogic` in FETCH until the word is valid.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word aligned.
- `FETCH_STATE`, default 4'd0: `statelogic` encoding of the FETCH state.
- `TIMEOUT_CYCLES`, default 16: watchdog limit. Used only with `FETCH_TIMEOUT_EN`.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `state`  in  4  current `statelogic` state.
- `mem_rdata`  in  32  instruction memory read data.
- `mem_ready`  in  1  memory accepts the request; `mem_rdata` valid this cycle.
- `pc_wr`  in  1  PC overwrite strobe (branch/jump).
- `pc_wr_data`  in  32  new PC value.
- `mem_req`  out  1  read request.
- `mem_addr`  out  32  read address (equal to `pc`).
- `pc`  out  32  current program counter.
- `op`  out  6  IR[31:26].
- `rs`, `rt`, `rd`  out  5 each  IR[25:21], IR[20:16], IR[15:11].
- `funct`  out  6  IR[5:0].
- `imm`  out  16  IR[15:0].
- `fetch_done`  out  1  one-cycle pulse: new instruction is in the IR.
- `stall`  out  1  `statelogic` must hold FETCH.
- `bus_err`  out  1  sticky fetch-timeout flag. Present only with `FETCH_TIMEOUT_EN`.

## Operation
- FSM states:
  - IDLE: go to REQ when `state==FETCH_STATE`.
  - REQ: `mem_req=1`. On `mem_ready`, go to DONE.
  - DONE: `fetch_done=1` for one cycle. Go to WAIT.
  - WAIT: go to IDLE when `state!=FETCH_STATE`. This prevents a second fetch while `statelogic` is still in FETCH.
- Reset values: FSM=IDLE, `pc=RESET_PC`, IR=32'h0, so `op`=0 and all fields are 0. `mem_req`=0, `fetch_done`=0, `bus_err`=0.
- On the REQ cycle where `mem_ready=1`:
  - IR ← `mem_rdata`.
  - `pc` ← `pc`+4, modulo 2^32. 32'hFFFF_FFFC wraps to 0.
- `pc_wr` loads `pc_wr_data` with bits [1:0] forced to 00. It is accepted in any FSM state.
- `pc_wr` in the same cycle as a fetch completion: `pc_wr` wins and no increment occurs. The IR still loads.
- `pc_wr` while in REQ: `mem_addr` follows the new `pc` from the next cycle. The request stays asserted.
- `stall = (state==FETCH_STATE) && !(FSM==DONE || FSM==WAIT)`. This is combinational from the registered FSM.
- IR holds its value outside fetch completion. `op` is stable for the whole instruction.
- Reset mid-fetch aborts the fetch. `mem_req`=0 the next cycle and any memory response is ignored.

## Timing
- All outputs except `stall` are registered.
- `state` becomes FETCH at cycle t → `mem_req`=1 from t+1.
- `mem_ready` at cycle k → `mem_req`=0, `fetch_done`=1, new `op`, and `pc`+4 at k+1.
- Minimum fetch latency with a zero-wait memory: 2 cycles from `state`=FETCH to `fetch_done`.
- `mem_addr` is held stable while `mem_req`=1, except after `pc_wr`.

## Configuration
- `FETCH_TIMEOUT_EN` defined:
  - A counter runs while in REQ.
  - After `TIMEOUT_CYCLES` cycles without `mem_ready`, the fetch completes with IR=32'h0 (NOP) and `pc` unchanged.
  - `fetch_done` pulses and `bus_err` is set until reset.
- Not defined: no counter and no `bus_err` port. REQ waits indefinitely.

## Structure
- Shared package `cpu_pkg`:
  - `statelogic` state encodings, including FETCH=4'd0.
  - Opcode constants: R-type 6'h00, LW 6'h23, SW 6'h2B, BEQ 6'h04, J 6'h02.
  - NOP word and `RESET_PC` default.
- No sub-module is required. The optional timeout counter stays inline under the macro.

## Test plan
- Reset, then `state`=0 with `mem_ready` one cycle after request and `mem_rdata`=32'h2002_0005 → `mem_addr`=0, `op`=6'h08, `rt`=2, `imm`=5, `pc`=4, one `fetch_done` pulse.
- Memory with 3 wait cycles → `mem_req` held 4 cycles, `stall` high throughout, `mem_addr` constant.
- `state` held at 0 for 5 cycles after `fetch_done` → no second `mem_req`, `pc` unchanged.
- `pc_wr`=1 with `pc_wr_data`=32'h0000_0043 in the same cycle as `mem_ready` → `pc`=32'h40 (not 0x44), IR loaded.
- `pc`=32'hFFFF_FFFC fetch → `pc`=0. Reset asserted while `mem_req`=1 → `mem_req`=0, `pc`=`RESET_PC`, `op`=0 next cycle.
- With `FETCH_TIMEOUT_EN` and `mem_ready` tied low → after 16 cycles, `fetch_done` pulses, `op`=0, `bus_err`=1 and stays sticky.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle processor: statelogic encodings,
// opcodes, fetch sequencer states and reset constants.
package cpu_pkg;

   localparam logic [3:0] ST_FETCH   = 4'd0;
   localparam logic [3:0] ST_DECODE  = 4'd1;
   localparam logic [3:0] ST_MEMADR  = 4'd2;
   localparam logic [3:0] ST_MEMRD   = 4'd3;
   localparam logic [3:0] ST_MEMWB   = 4'd4;
   localparam logic [3:0] ST_MEMWR   = 4'd5;
   localparam logic [3:0] ST_RTYPEEX = 4'd6;
   localparam logic [3:0] ST_RTYPEWB = 4'd7;
   localparam logic [3:0] ST_BEQEX   = 4'd8;
   localparam logic [3:0] ST_JEX     = 4'd9;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   localparam logic [1:0] FS_IDLE = 2'd0;
   localparam logic [1:0] FS_REQ  = 2'd1;
   localparam logic [1:0] FS_DONE = 2'd2;
   localparam logic [1:0] FS_WAIT = 2'd3;

   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer and instruction register. Optional fetch
// watchdog and sticky bus_err port are enabled with `define FETCH_TIMEOUT_EN.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC       = RESET_PC_DEFAULT,
   parameter logic [3:0]  FETCH_STATE    = ST_FETCH,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  state,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   input  logic        pc_wr,
   input  logic [31:0] pc_wr_data,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   output logic [31:0] pc,
   output logic [5:0]  op,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [5:0]  funct,
   output logic [15:0] imm,
   output logic        fetch_done,
   output logic        stall,
`ifdef FETCH_TIMEOUT_EN
   output logic        bus_err,
`endif
   output logic [1:0]  dbg_fsm
);

   // Memory handshake: mem_req stays high until a rising edge sees mem_ready
   // high; that edge is the one transfer, and mem_rdata is sampled only there.
   logic [1:0]  fsm_q, fsm_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic        unused_ok;

`ifdef FETCH_TIMEOUT_EN
   logic [31:0] to_cnt_q, to_cnt_d;
   logic        bus_err_q, bus_err_d;
`endif

   always_comb begin
      fsm_d = fsm_q;
      pc_d  = pc_q;
      ir_d  = ir_q;
`ifdef FETCH_TIMEOUT_EN
      bus_err_d = bus_err_q;
`endif
      case (fsm_q)
         FS_IDLE: if (state == FETCH_STATE) fsm_d = FS_REQ;
         FS_REQ: begin
            if (mem_ready) begin
               fsm_d = FS_DONE;
               ir_d  = mem_rdata;
               pc_d  = pc_q + 32'd4;
            end
`ifdef FETCH_TIMEOUT_EN
            else if (to_cnt_q == TIMEOUT_CYCLES - 1) begin
               fsm_d     = FS_DONE;
               ir_d      = NOP_WORD;
               bus_err_d = 1'b1;
            end
`endif
         end
         FS_DONE: fsm_d = FS_WAIT;
         FS_WAIT: if (state != FETCH_STATE) fsm_d = FS_IDLE;
         default: fsm_d = FS_IDLE;
      endcase
      // A branch/jump write overrides the post-fetch increment.
      if (pc_wr) pc_d = align_word(pc_wr_data);
   end

`ifdef FETCH_TIMEOUT_EN
   always_comb begin
      to_cnt_d = 32'd0;
      if (fsm_q == FS_REQ && fsm_d == FS_REQ) to_cnt_d = to_cnt_q + 32'd1;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         fsm_q <= FS_IDLE;
         pc_q  <= RESET_PC;
         ir_q  <= NOP_WORD;
`ifdef FETCH_TIMEOUT_EN
         to_cnt_q  <= 32'd0;
         bus_err_q <= 1'b0;
`endif
      end else begin
         fsm_q <= fsm_d;
         pc_q  <= pc_d;
         ir_q  <= ir_d;
`ifdef FETCH_TIMEOUT_EN
         to_cnt_q  <= to_cnt_d;
         bus_err_q <= bus_err_d;
`endif
      end
   end

   assign mem_req    = (fsm_q == FS_REQ);
   assign fetch_done = (fsm_q == FS_DONE);
   assign mem_addr   = pc_q;
   assign pc         = pc_q;
   assign op         = ir_q[31:26];
   assign rs         = ir_q[25:21];
   assign rt         = ir_q[20:16];
   assign rd         = ir_q[15:11];
   assign funct      = ir_q[5:0];
   assign imm        = ir_q[15:0];
   assign stall      = (state == FETCH_STATE) && !(fsm_q == FS_DONE || fsm_q == FS_WAIT);
   assign dbg_fsm    = fsm_q;
`ifdef FETCH_TIMEOUT_EN
   assign bus_err    = bus_err_q;
`endif

   assign unused_ok = ^{pc_wr_data[1:0], TIMEOUT_CYCLES[0]};

endmodule
